serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor computing diff = a − b − bin one bit per clock, LSB first, using a registered borrow. It is the inverse-direction counterpart of the lab's combinational full adder: one full-subtractor cell is reused over WIDTH cycles behind a start/done handshake. It sits in the lab arithmetic datapath as a low-area subtract unit driven by a simple controller or testbench.

---
 rtl/serial_subtractor_if.sv | 34 +++
 rtl/serial_subtractor.sv | 129 ++++++++++++
 tb/tb_serial_subtractor.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus for serial_subtractor.
// The ovf signal exists only when SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, bin,
    input  ready, busy, done, diff, bout
`ifdef SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, bin,
    output ready, busy, done, diff, bout
`ifdef SUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor cell reused over WIDTH cycles.
// Define SUB_OVF_EN to add the registered signed-overflow output.
//
// state | meaning
// IDLE  | ready, waiting for start; operands latched on accept
// SHIFT | one difference bit per cycle, WIDTH cycles
// DONE  | one-cycle done pulse, result valid
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   sub
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic a0, b0, d_bit, br_nxt;

  always_comb begin
    a0     = a_q[0];
    b0     = b_q[0];
    d_bit  = a0 ^ b0 ^ br_q;
    br_nxt = (~a0 & b0) | (~(a0 ^ b0) & br_q);

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
`ifdef SUB_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (sub.start) begin
          a_d     = sub.a;
          b_d     = sub.b;
          br_d    = sub.bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        a_d    = {1'b0, a_q[WIDTH-1:1]};
        b_d    = {1'b0, b_q[WIDTH-1:1]};
        br_d   = br_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          bout_d  = br_nxt;
`ifdef SUB_OVF_EN
          // Borrow into the MSB differing from borrow out of it is signed overflow.
          ovf_d   = br_q ^ br_nxt;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d == SHIFT);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sub.ready = ready_q;
  assign sub.busy  = busy_q;
  assign sub.done  = done_q;
  assign sub.diff  = diff_q;
  assign sub.bout  = bout_q;
`ifdef SUB_OVF_EN
  assign sub.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8): vector table plus
// hand-written sequences for ignored starts and mid-operation reset.
module tb_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) sif ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .sub(sif));

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] ediff;
    logic         ebout;
    logic         eovf;
  } vec_t;

  vec_t vecs[11];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Runs one operation; optionally pulses start during SHIFT cycle 'glitch'
  // and/or during the DONE cycle, both of which must be ignored.
  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tbin, input logic [W-1:0] ediff, input logic ebout,
                        input logic eovf, input int glitch, input bit start_in_done);
    int lat;
    bit seen;
    bit busy_ok;
    check({nm, ":ready_before"}, 32'(sif.ready), 32'd1);
    sif.a = ta; sif.b = tb; sif.bin = tbin; sif.start = 1'b1;
    tick();
    sif.start = 1'b0; sif.a = ~ta; sif.b = ~tb; sif.bin = ~tbin;
    check({nm, ":busy_after_e0"}, 32'(sif.busy), 32'd1);
    lat = 0; seen = 0; busy_ok = 1;
    for (int i = 1; i <= W + 3 && !seen; i++) begin
      if (i == glitch) begin
        sif.start = 1'b1; sif.a = 8'hAA; sif.b = 8'h55;
      end
      tick();
      if (i == glitch) sif.start = 1'b0;
      if (sif.done) begin
        seen = 1; lat = i;
      end else if (!sif.busy || sif.ready) begin
        busy_ok = 0;
      end
    end
    check({nm, ":busy_during_shift"}, 32'(busy_ok), 32'd1);
    check({nm, ":latency"}, 32'(lat), 32'(W));
    check({nm, ":diff"}, 32'(sif.diff), 32'(ediff));
    check({nm, ":bout"}, 32'(sif.bout), 32'(ebout));
`ifdef SUB_OVF_EN
    check({nm, ":ovf"}, 32'(sif.ovf), 32'(eovf));
`endif
    if (start_in_done) begin
      sif.start = 1'b1; sif.a = 8'h44; sif.b = 8'h11;
    end
    tick();
    sif.start = 1'b0;
    check({nm, ":done_one_cycle"}, {30'd0, sif.done, sif.busy}, 32'd0);
    check({nm, ":ready_after"}, 32'(sif.ready), 32'd1);
    if (start_in_done) begin
      tick();
      check({nm, ":done_start_ignored"}, {sif.ready, sif.busy, sif.bout, sif.diff}, {1'b1, 1'b0, ebout, ediff});
    end
  endtask

  initial begin
    int dpulses;
    vecs[0]  = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1]  = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2]  = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3]  = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[5]  = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[6]  = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[7]  = '{8'h7F, 8'h80, 1'b1, 8'hFE, 1'b1, 1'b1};
    vecs[8]  = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};
    vecs[9]  = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
    vecs[10] = '{8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0};

    sif.start = 1'b0; sif.a = '0; sif.b = '0; sif.bin = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("reset:ready", 32'(sif.ready), 32'd1);
    check("reset:busy_done", {30'd0, sif.busy, sif.done}, 32'd0);
    check("reset:diff_bout", {23'd0, sif.bout, sif.diff}, 32'd0);
`ifdef SUB_OVF_EN
    check("reset:ovf", 32'(sif.ovf), 32'd0);
`endif

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin,
             vecs[i].ediff, vecs[i].ebout, vecs[i].eovf, -1, 1'b0);

    run_op("ignored_starts", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 3, 1'b1);

    // Abort with reset in SHIFT cycle 4 of an operation.
    sif.a = 8'h33; sif.b = 8'h11; sif.bin = 1'b0; sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort:ready_busy", {30'd0, sif.ready, sif.busy}, 32'd2);
    check("abort:diff_bout", {23'd0, sif.bout, sif.diff}, 32'd0);
`ifdef SUB_OVF_EN
    check("abort:ovf", 32'(sif.ovf), 32'd0);
`endif
    dpulses = 0;
    for (int i = 0; i < W + 3; i++) begin
      if (sif.done) dpulses++;
      tick();
    end
    check("abort:no_done", 32'(dpulses), 32'd0);
    run_op("after_abort", 8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
